tmcu_uart_rx_deser: RTL and testbench
=====================================

// Module: tmcu_uart_rx_deser
// PURPOSE
//  Serial-to-parallel UART receive front end: synchronises the rx pin, detects and validates start bits,
//  majority-votes each bit at mid-bit, checks parity/stop and presents bytes on a 1-entry valid/ack holding
//  register. Sits between the rx pad and the UART APB register block (feeds its RX data / status words).
// PARAMETERS
//  DATA_BITS    8  data bits per frame, LSB first (legal 5..8); rx_data upper bits zero-filled
//  PARITY       0  0 = none, 1 = even, 2 = odd
//  SYNC_STAGES  2  flops in rx input synchroniser (>=2)
// PORTS
//  clk         in   1   clock
//  rst_n       in   1   reset, asynchronous, active-low
//  enable      in   1   receiver enable; low aborts any frame in progress
//  baud_div    in   16  clk cycles per bit; values < 4 treated as 4
//  rx          in   1   asynchronous serial input, idle high
//  rx_data     out  8   received byte (valid while rx_valid)
//  rx_valid    out  1   holding register full
//  rx_ack      in   1   consumer pop; clears rx_valid next edge
//  frame_err   out  1   sticky: stop bit sampled 0
//  parity_err  out  1   sticky: parity mismatch
//  overrun     out  1   sticky: frame completed while holding register full
//  err_clr     in   1   clears all three sticky flags
//  busy        out  1   FSM not in IDLE
// BEHAVIOUR
//  - Reset: rx_data=0, rx_valid=0, all err flags=0, busy=0, FSM=IDLE, synchroniser flops=1.
//  - Sync: rx passes SYNC_STAGES flops -> rx_s; all decisions use rx_s. Pin-to-FSM latency = SYNC_STAGES clk.
//  - Per-bit counter cnt 0..div-1 (div = baud_div latched at start detection; mid-frame changes ignored).
//    mid = div>>1; samples at cnt = mid-1, mid, mid+1; bit value = majority of 3; decision at cnt = mid+1.
//  - FSM: IDLE -> START on rx_s 1->0 while enable (cnt cleared to 0 that cycle).
//    START: decision 0 -> DATA; decision 1 -> IDLE (glitch rejected, nothing flagged).
//    DATA: shift bit in LSB-first; after DATA_BITS bits -> PARITY if PARITY!=0, else STOP.
//    PARITY: compare with even/odd of data bits; mismatch sets parity_err -> STOP.
//    STOP: decision 1 -> push byte, -> IDLE immediately (half-bit early, so back-to-back starts are caught).
//          decision 0 -> set frame_err, no push, -> BRK; BRK waits rx_s==1 then -> IDLE.
//  - Push: rx_data<=byte, rx_valid<=1 on the STOP decision edge. Byte with parity error is still pushed.
//  - Push while rx_valid=1 and no rx_ack: new byte dropped, old kept, overrun set.
//  - Push and rx_ack same cycle: new byte loaded, rx_valid stays 1, no overrun.
//  - rx_ack with rx_valid=0: ignored. rx_data holds last value after pop.
//  - Sticky flag set and err_clr same cycle: set wins (flag=1).
//  - enable low: FSM -> IDLE next edge, partial frame discarded, no flags; rx_valid/rx_data/flags hold.
//  - busy = (state != IDLE), registered from state.
// STRUCTURE
//  - tmcu_uart_pkg: rx FSM state enum (IDLE, START, DATA, PARITY, STOP, BRK), parity-mode constants
//    (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2), MIN_BAUD_DIV=4.
//  - Sub-module tmcu_uart_sync: SYNC_STAGES-deep synchroniser, reset value 1.
//  - Top: bit counter, bit index, 3-sample vote, shift register, FSM, holding register, sticky flags.
// TESTING
//  1. baud_div=16, PARITY=0, frame 0xA5 stop=1 -> rx_valid=1, rx_data=8'hA5, all flags 0; rx_ack -> rx_valid=0 next clk.
//  2. rx low for 3 clk then high (baud_div=16) -> START rejects, busy returns 0, rx_valid=0, no flags.
//  3. Frame 0x3C with stop=0 held low 3 bit times -> frame_err=1, rx_valid=0, busy until rx high; then 0x55 -> rx_data=8'h55.
//  4. Back-to-back 0x11, 0x22, no ack -> rx_data=8'h11, overrun=1; err_clr -> overrun=0; ack on push cycle of 0x22 -> rx_data=8'h22, overrun=0.
//  5. PARITY=1, 0x07 with parity bit 0 -> rx_data=8'h07, rx_valid=1, parity_err=1; correct bit 1 -> parity_err stays 0.
//  6. enable dropped at DATA bit 3 -> busy=0 next clk, no push; re-enable, frame 0xF0 -> rx_data=8'hF0. rst_n mid-frame -> all outputs reset values.

Source files
------------

// File: rtl/tmcu_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tmcu_uart_pkg
// Purpose  : Shared types and constants for the UART receive path.
//            Contains the rx FSM state encoding, the parity-mode
//            encodings and the minimum usable bit period.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package tmcu_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BRK    = 3'd5
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Shortest bit period that still leaves room for three mid-bit samples.
    localparam logic [15:0] MIN_BAUD_DIV = 16'd4;

endpackage
`default_nettype wire

// File: rtl/tmcu_uart_sync.sv
`default_nettype none
// ============================================================================
// Module   : tmcu_uart_sync
// Purpose  : Multi-flop synchroniser for the asynchronous rx pin. Resets
//            to 1 so that an idle line is not mistaken for a start bit.
// Ports    : clk    - clock
//            rst_n  - asynchronous active-low reset
//            rx     - asynchronous serial input
//            rx_s   - synchronised serial input
// Revision : 1.0  initial release
// ============================================================================
module tmcu_uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/tmcu_uart_rx_deser.sv
`default_nettype none
// ============================================================================
// Module   : tmcu_uart_rx_deser
// Purpose  : UART receive front end. Synchronises rx, validates the start
//            bit, majority-votes three mid-bit samples per bit, checks
//            parity and stop, and presents bytes on a one-entry holding
//            register with valid/ack handshake and sticky error flags.
// Ports    : clk, rst_n            - clock, async active-low reset
//            enable                - receiver enable (low aborts a frame)
//            baud_div[15:0]        - clk cycles per bit (min 4)
//            rx                    - serial input, idle high
//            rx_data[7:0]          - received byte
//            rx_valid / rx_ack     - holding register full / pop
//            frame_err, parity_err, overrun - sticky flags
//            err_clr               - clears the sticky flags
//            busy                  - receiver not idle
// Revision : 1.0  initial release
// ============================================================================
module tmcu_uart_rx_deser
    import tmcu_uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] baud_div,
    input  logic        rx,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ack,
    output logic        frame_err,
    output logic        parity_err,
    output logic        overrun,
    input  logic        err_clr,
    output logic        busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic        rx_s;
    logic        r_rx_prev;
    rx_state_e   r_state;
    logic [15:0] r_div;
    logic [15:0] r_cnt;
    logic        r_samp0;
    logic        r_samp1;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;

    logic [15:0] w_eff_div;
    logic [15:0] w_mid;
    logic        w_decide;
    logic        w_vote;
    logic        w_par_exp;
    logic        w_push;
    logic        w_frame_set;
    logic        w_par_set;

    tmcu_uart_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .rx_s  (rx_s)
    );

    assign w_eff_div = (baud_div < MIN_BAUD_DIV) ? MIN_BAUD_DIV : baud_div;
    assign w_mid     = r_div >> 1;
    // Third sample is the live rx_s on the decision cycle.
    assign w_decide  = (r_cnt == w_mid + 16'd1);
    assign w_vote    = (r_samp0 & r_samp1) | (r_samp0 & rx_s) | (r_samp1 & rx_s);
    // Unused upper shift bits are cleared at start, so reducing all 8 is safe.
    assign w_par_exp = (PARITY == PAR_ODD) ? ~(^r_shift) : (^r_shift);

    assign w_push      = enable && (r_state == ST_STOP) && w_decide && w_vote;
    assign w_frame_set = enable && (r_state == ST_STOP) && w_decide && !w_vote;
    assign w_par_set   = enable && (r_state == ST_PARITY) && w_decide && (w_vote != w_par_exp);

    // Receive FSM with bit timing, sampling and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            busy      <= 1'b0;
            r_rx_prev <= 1'b1;
            r_div     <= MIN_BAUD_DIV;
            r_cnt     <= 16'd0;
            r_samp0   <= 1'b1;
            r_samp1   <= 1'b1;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            r_rx_prev <= rx_s;
            if (r_cnt == w_mid - 16'd1) r_samp0 <= rx_s;
            if (r_cnt == w_mid)         r_samp1 <= rx_s;
            if (r_cnt == r_div - 16'd1) r_cnt <= 16'd0;
            else                        r_cnt <= r_cnt + 16'd1;

            if (!enable) begin
                r_state <= ST_IDLE;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_rx_prev && !rx_s) begin
                            r_state   <= ST_START;
                            busy      <= 1'b1;
                            r_cnt     <= 16'd0;
                            r_div     <= w_eff_div;
                            r_bit_idx <= 3'd0;
                            r_shift   <= 8'd0;
                        end
                    end
                    ST_START: begin
                        if (w_decide) begin
                            if (w_vote) begin
                                r_state <= ST_IDLE;
                                busy    <= 1'b0;
                            end else begin
                                r_state <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_decide) begin
                            r_shift[r_bit_idx] <= w_vote;
                            if (r_bit_idx == LAST_BIT) begin
                                r_state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (w_decide) r_state <= ST_STOP;
                    end
                    ST_STOP: begin
                        // Leave at mid stop bit so a back-to-back start edge is seen.
                        if (w_decide) begin
                            if (w_vote) begin
                                r_state <= ST_IDLE;
                                busy    <= 1'b0;
                            end else begin
                                r_state <= ST_BRK;
                            end
                        end
                    end
                    ST_BRK: begin
                        if (rx_s) begin
                            r_state <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Holding register and sticky flags; a new set beats err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= 8'd0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (w_push) begin
                if (!rx_valid || rx_ack) begin
                    rx_data  <= r_shift;
                    rx_valid <= 1'b1;
                end
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end

            if (w_push && rx_valid && !rx_ack) overrun <= 1'b1;
            else if (err_clr)                  overrun <= 1'b0;

            if (w_frame_set)  frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;

            if (w_par_set)    parity_err <= 1'b1;
            else if (err_clr) parity_err <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tmcu_uart_rx_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmcu_uart_rx_deser
// Purpose  : Self-checking bench for tmcu_uart_rx_deser. Two instances:
//            u_dut0 without parity, u_dut1 with even parity. A frame-level
//            reference model predicts the holding register and flags.
// Revision : 1.0  initial release
// ============================================================================
module tb_tmcu_uart_rx_deser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] baud_div = 16'd16;
    logic        rx0 = 1'b1;
    logic        rx1 = 1'b1;
    logic        rx_ack = 1'b0;
    logic        err_clr = 1'b0;

    logic [7:0]  data0, data1;
    logic        v0, v1, fe0, fe1, pe0, pe1, ov0, ov1, b0, b1;

    always #5 clk = ~clk;

    tmcu_uart_rx_deser #(.DATA_BITS(8), .PARITY(0), .SYNC_STAGES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .baud_div(baud_div), .rx(rx0),
        .rx_data(data0), .rx_valid(v0), .rx_ack(rx_ack), .frame_err(fe0),
        .parity_err(pe0), .overrun(ov0), .err_clr(err_clr), .busy(b0)
    );

    tmcu_uart_rx_deser #(.DATA_BITS(8), .PARITY(1), .SYNC_STAGES(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .baud_div(baud_div), .rx(rx1),
        .rx_data(data1), .rx_valid(v1), .rx_ack(rx_ack), .frame_err(fe1),
        .parity_err(pe1), .overrun(ov1), .err_clr(err_clr), .busy(b1)
    );

    int sel = 0;
    logic [7:0] o_data;
    logic o_valid, o_fe, o_pe, o_ov, o_busy;
    assign o_data  = (sel != 0) ? data1 : data0;
    assign o_valid = (sel != 0) ? v1  : v0;
    assign o_fe    = (sel != 0) ? fe1 : fe0;
    assign o_pe    = (sel != 0) ? pe1 : pe0;
    assign o_ov    = (sel != 0) ? ov1 : ov0;
    assign o_busy  = (sel != 0) ? b1  : b0;

    int errors = 0;
    int checks = 0;

    // Reference model state (frame-level view of the receiver)
    logic [7:0] m_data;
    logic m_valid, m_fe, m_pe, m_ov;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int eff_div(input logic [15:0] bd);
        return (bd < 16'd4) ? 4 : int'(bd);
    endfunction

    task automatic drive(input logic b, input int n);
        if (sel != 0) rx1 = b; else rx0 = b;
        tick(n);
    endtask

    task automatic model_reset();
        m_data = 8'd0; m_valid = 1'b0; m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
    endtask

    // Frame outcome: stop=0 -> frame error only; else push with overrun rules.
    task automatic model_frame(input logic [7:0] d, input int pmode, input bit par_ok,
                               input bit stop, input bit ack_at_push);
        if (pmode != 0 && !par_ok) m_pe = 1'b1;
        if (!stop) begin
            m_fe = 1'b1;
        end else if (m_valid && !ack_at_push) begin
            m_ov = 1'b1;
        end else begin
            m_data  = d;
            m_valid = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int pmode, input bit par_ok,
                              input bit stop, input int gap);
        int div;
        logic pb;
        div = eff_div(baud_div);
        drive(1'b0, div);
        for (int i = 0; i < 8; i++) drive(d[i], div);
        if (pmode != 0) begin
            pb = (pmode == 1) ? ^d : ~(^d);
            if (!par_ok) pb = ~pb;
            drive(pb, div);
        end
        if (stop) drive(1'b1, div);
        else      drive(1'b0, 3 * div);
        drive(1'b1, gap);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},  o_valid, m_valid);
        chk({tag, ".data"},   o_data,  m_data);
        chk({tag, ".ferr"},   o_fe,    m_fe);
        chk({tag, ".perr"},   o_pe,    m_pe);
        chk({tag, ".ovr"},    o_ov,    m_ov);
        chk({tag, ".busy"},   o_busy,  1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        model_reset();
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        if (m_valid) m_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        bit st, pok;
        int g;

        model_reset();
        // Start edge at T0 reaches FSM at edge 3; bit j decided at edge 3+j*div+mid+2.
        // ---- 1: basic frame, ack ----
        sel = 0; baud_div = 16'd16; enable = 1'b1;
        do_reset();
        check_all("reset");
        send_frame(8'hA5, 0, 1, 1, 40);
        model_frame(8'hA5, 0, 1, 1, 0);
        check_all("t1_a5");
        rx_ack = 1'b1;
        tick(1);
        chk("t1_ack_valid", o_valid, 1'b0);
        rx_ack = 1'b0;
        m_valid = 1'b0;

        // ---- 2: glitch rejected ----
        rx0 = 1'b0;
        tick(3);
        chk("t2_busy_hi", o_busy, 1'b1);
        rx0 = 1'b1;
        tick(30);
        check_all("t2_glitch");

        // ---- 3: framing error then recovery ----
        fork
            send_frame(8'h3C, 0, 1, 0, 40);
            begin
                tick(176);
                chk("t3_busy_brk", o_busy, 1'b1);
                chk("t3_ferr_early", o_fe, 1'b1);
            end
        join
        model_frame(8'h3C, 0, 1, 0, 0);
        check_all("t3_ferr");
        send_frame(8'h55, 0, 1, 1, 40);
        model_frame(8'h55, 0, 1, 1, 0);
        check_all("t3_55");

        // ---- 4: back-to-back overrun, clear, ack on push cycle ----
        do_reset();
        send_frame(8'h11, 0, 1, 1, 0);
        model_frame(8'h11, 0, 1, 1, 0);
        send_frame(8'h22, 0, 1, 1, 40);
        model_frame(8'h22, 0, 1, 1, 0);
        check_all("t4_ovr");
        pulse_clr();
        check_all("t4_clr");
        fork
            send_frame(8'h22, 0, 1, 1, 40);
            begin
                tick(156);
                rx_ack = 1'b1;
                chk("t4_pre_push", o_data, 8'h11);
                tick(1);
                rx_ack = 1'b0;
                chk("t4_push_data", o_data, 8'h22);
                chk("t4_push_valid", o_valid, 1'b1);
            end
        join
        model_frame(8'h22, 0, 1, 1, 1);
        check_all("t4_ackpush");

        // ---- 5: even parity ----
        sel = 1;
        do_reset();
        send_frame(8'h07, 1, 0, 1, 40);
        model_frame(8'h07, 1, 0, 1, 0);
        check_all("t5_bad");
        pulse_ack();
        pulse_clr();
        send_frame(8'h07, 1, 1, 1, 40);
        model_frame(8'h07, 1, 1, 1, 0);
        check_all("t5_good");

        // ---- 6: enable drop, mid-frame baud change, async reset ----
        sel = 0;
        do_reset();
        fork
            send_frame(8'hAA, 0, 1, 1, 40);
            begin
                tick(73);
                chk("t6_busy_data", o_busy, 1'b1);
                enable = 1'b0;
                tick(1);
                chk("t6_busy_drop", o_busy, 1'b0);
            end
        join
        enable = 1'b1;
        tick(4);
        check_all("t6_abort");
        fork
            send_frame(8'hF0, 0, 1, 1, 40);
            begin
                tick(40);
                baud_div = 16'd5;
            end
        join
        baud_div = 16'd16;
        model_frame(8'hF0, 0, 1, 1, 0);
        check_all("t6_f0");
        fork
            send_frame(8'h99, 0, 1, 1, 20);
            begin
                tick(60);
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                check_all("t6_async_rst");
            end
        join
        rst_n = 1'b1;
        tick(5);
        check_all("t6_after_rst");

        // ---- random frames, no parity ----
        sel = 0;
        for (int k = 0; k < 14; k++) begin
            baud_div = 16'($urandom_range(0, 24));
            d  = 8'($urandom);
            st = ($urandom_range(0, 5) != 0);
            g  = 2 * eff_div(baud_div) + 8;
            send_frame(d, 0, 1, st, g);
            model_frame(d, 0, 1, st, 0);
            check_all($sformatf("rnd%0d", k));
            if ($urandom_range(0, 1) == 1) pulse_ack();
            if ($urandom_range(0, 3) == 0) pulse_clr();
            check_all($sformatf("rnd%0d_post", k));
        end

        // ---- random frames, even parity ----
        sel = 1;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            baud_div = 16'($urandom_range(4, 20));
            d   = 8'($urandom);
            pok = ($urandom_range(0, 2) != 0);
            g   = 2 * eff_div(baud_div) + 8;
            send_frame(d, 1, pok, 1, g);
            model_frame(d, 1, pok, 1, 0);
            check_all($sformatf("prnd%0d", k));
            pulse_ack();
            if ($urandom_range(0, 1) == 1) pulse_clr();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time guard so the bench always terminates.
    initial begin
        #5000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
